// File: rtl/pot_scan_a2d.sv
`default_nettype none
// ============================================================================
// Module   : pot_scan_a2d
// Purpose  : Free-running scanner for the six equalizer slide pots. It runs
//            its own SPI master to the ADC128S 8-channel ADC and holds the
//            most recent 12-bit reading of each pot for the band-gain and
//            volume logic downstream.
// Ports    : clk       - system clock
//            rst       - synchronous reset, active-high
//            SS_n      - ADC chip select, active low
//            SCLK      - SPI clock, idles high
//            MOSI      - SPI data to ADC (channel address in bits 13:11)
//            MISO      - SPI data from ADC
//            LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume
//                      - latest 12-bit pot readings
//            scan_done - 1-clk pulse when the volume register is written,
//                        i.e. once all six pots have been refreshed
// Revision : 1.0  initial release
// ============================================================================
module pot_scan_a2d #(
    parameter int         SCLK_DIV = 32,    // clk cycles per SCLK period; even, >= 4
    parameter int         GAP_CYC  = 64,    // clk cycles SS_n stays high between frames
    parameter logic [2:0] CH_LP    = 3'd1,
    parameter logic [2:0] CH_B1    = 3'd0,
    parameter logic [2:0] CH_B2    = 3'd4,
    parameter logic [2:0] CH_B3    = 3'd2,
    parameter logic [2:0] CH_HP    = 3'd3,
    parameter logic [2:0] CH_VOL   = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] volume,
    output logic        scan_done
);

    localparam int               HALF      = SCLK_DIV / 2;
    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    // Half-periods 0..31 are the 16 low/high SCLK periods; half 32 is a
    // trailing high hold before SS_n is released.
    localparam logic [5:0]       TAIL_HALF = 6'd32;
    localparam logic [2:0]       LAST_SLOT = 3'd5;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_FRONT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_BACK  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       half_q, half_d;
    logic             sclk_q, sclk_d;
    logic             sclk_dly_q, sclk_dly_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic [14:0]      tx_q, tx_d;
    logic [11:0]      rx_q, rx_d;
    logic [2:0]       idx_q, idx_d;
    logic             prime_q, prime_d;
    logic [11:0]      pot_q [6];
    logic [11:0]      pot_d [6];
    logic             scan_done_q, scan_done_d;

    logic [2:0]       slot_ch;
    logic [2:0]       prev_slot;
    logic [15:0]      frame_word;
    logic [5:0]       half_nx;
    logic             sclk_rise;

    // Channel addressed by the current slot.
    always_comb begin
        slot_ch = CH_LP;
        case (idx_q)
            3'd0:    slot_ch = CH_LP;
            3'd1:    slot_ch = CH_B1;
            3'd2:    slot_ch = CH_B2;
            3'd3:    slot_ch = CH_B3;
            3'd4:    slot_ch = CH_HP;
            3'd5:    slot_ch = CH_VOL;
            default: slot_ch = CH_LP;
        endcase
    end

    // The ADC returns the conversion of the previous frame's channel, so the
    // data received now belongs to the previous slot.
    assign prev_slot  = (idx_q == 3'd0) ? LAST_SLOT : (idx_q - 3'd1);
    assign frame_word = {2'b00, slot_ch, 11'd0};
    assign half_nx    = half_q + 6'd1;
    // Delayed rise detect: true on the first clk SCLK is seen high.
    assign sclk_rise  = sclk_q & ~sclk_dly_q & ~ss_n_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        sclk_d      = sclk_q;
        sclk_dly_d  = sclk_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        idx_d       = idx_q;
        prime_d     = prime_q;
        pot_d       = pot_q;
        scan_done_d = 1'b0;

        // Only the last 12 bits shifted in survive, which are MISO bits 11:0.
        if (sclk_rise) begin
            rx_d = {rx_q[10:0], MISO};
        end

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_FRONT;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = frame_word[15];
                    tx_d    = frame_word[14:0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_FRONT: begin
                if (cnt_q == HALF_LAST) begin
                    // First falling edge; MOSI already holds bit 15.
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (half_q == TAIL_HALF) begin
                        state_d = ST_BACK;
                        ss_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        half_d = half_nx;
                        sclk_d = half_nx[0] | (half_nx == TAIL_HALF);
                        // Even half-periods start with a falling edge: next bit out.
                        if (!half_nx[0] && (half_nx != TAIL_HALF)) begin
                            mosi_d = tx_q[14];
                            tx_d   = {tx_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_BACK: begin
                state_d = ST_GAP;
                cnt_d   = '0;
                idx_d   = (idx_q == LAST_SLOT) ? 3'd0 : (idx_q + 3'd1);
                if (prime_q) begin
                    // First frame after reset carries no valid conversion.
                    prime_d = 1'b0;
                end else begin
                    for (int i = 0; i < 6; i++) begin
                        if (prev_slot == 3'(i)) begin
                            pot_d[i] = rx_q;
                        end
                    end
                    scan_done_d = (prev_slot == LAST_SLOT);
                end
            end

            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_GAP;
            cnt_q       <= '0;
            half_q      <= '0;
            sclk_q      <= 1'b1;
            sclk_dly_q  <= 1'b1;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            idx_q       <= 3'd0;
            prime_q     <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= '0;
            end
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            sclk_q      <= sclk_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            idx_q       <= idx_d;
            prime_q     <= prime_d;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= pot_d[i];
            end
            scan_done_q <= scan_done_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign LP_pot    = pot_q[0];
    assign B1_pot    = pot_q[1];
    assign B2_pot    = pot_q[2];
    assign B3_pot    = pot_q[3];
    assign HP_pot    = pot_q[4];
    assign volume    = pot_q[5];
    assign scan_done = scan_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_a2d.sv
`default_nettype none
// ============================================================================
// Module   : tb_pot_scan_a2d
// Purpose  : Self-checking bench for pot_scan_a2d with a behavioural ADC128S
//            that returns a programmable 12-bit value per channel.
// Revision : 1.0  initial release
// ============================================================================
module tb_pot_scan_a2d;

    localparam int FRAME = 609;
    localparam int SCAN  = 6 * FRAME;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, scan_done;
    logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume;

    int checks = 0;
    int errors = 0;

    // Slot order LP, B1, B2, B3, HP, VOL -> ADC channel
    int slot_ch  [6] = '{1, 0, 4, 2, 3, 7};
    int exp_addr [7] = '{1, 0, 4, 2, 3, 7, 1};

    // ADC model state
    logic [11:0] val [8];
    logic [15:0] din       = 16'h0;
    logic [15:0] sh        = 16'h0;
    logic [2:0]  prev_addr = 3'd0;
    logic [15:0] frame_log [$];

    pot_scan_a2d dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .LP_pot    (LP_pot),
        .B1_pot    (B1_pot),
        .B2_pot    (B2_pot),
        .B3_pot    (B3_pot),
        .HP_pot    (HP_pot),
        .volume    (volume),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    // ---------------- ADC128S behavioural model ----------------
    always @(negedge SS_n) begin
        din <= 16'h0;
        sh  <= {4'h0, val[prev_addr]};
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0) begin
            MISO <= sh[15];
            sh   <= {sh[14:0], 1'b0};
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) din <= {din[14:0], MOSI};
    end

    always @(posedge SS_n) begin
        frame_log.push_back(din);
        prev_addr <= din[13:11];
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pot(input int i);
        case (i)
            0:       return LP_pot;
            1:       return B1_pot;
            2:       return B2_pot;
            3:       return B3_pot;
            4:       return HP_pot;
            default: return volume;
        endcase
    endfunction

    // ---------------- T1 reset ----------------
    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b expected 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pot(i) !== 12'h000) begin errors++; $display("FAIL reset_pot%0d: got %h expected 000", i, pot(i)); end
        end
        rst = 1'b0;
        n = 0;
        while (SS_n !== 1'b0 && n < 200) begin tick(); n++; end
        checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL first_frame_start: got SS_n=%b expected 0 within 200 clks", SS_n); end
        // 208 clks after SS_n falls the frame sits in an SCLK-low half of SHIFT
        repeat (208) tick();
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL mid_shift_sclk: got %b expected 0", SCLK); end
        rst = 1'b1;
        tick();
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL midframe_reset_ss_n: got %b expected 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL midframe_reset_sclk: got %b expected 1", SCLK); end
        repeat (4) tick();
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL midframe_reset_mosi: got %b expected 0", MOSI); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pot(i) !== 12'h000) begin errors++; $display("FAIL midframe_reset_pot%0d: got %h expected 000", i, pot(i)); end
        end
        rst = 1'b0;
        frame_log.delete();
    endtask

    // ---------------- T2 addressing ----------------
    task automatic test_addressing();
        int   rises = 0;
        int   n     = 0;
        logic pss   = SS_n;
        logic [15:0] w;
        while (rises < 7 && n < 7 * FRAME + 200) begin
            tick(); n++;
            if (pss === 1'b0 && SS_n === 1'b1) begin
                rises++;
                if (rises == 1) begin
                    repeat (2) tick();
                    n += 2;
                    for (int i = 0; i < 6; i++) begin
                        checks++;
                        if (pot(i) !== 12'h000) begin errors++; $display("FAIL prime_discard_pot%0d: got %h expected 000", i, pot(i)); end
                    end
                end
            end
            pss = SS_n;
        end
        checks++; if (rises != 7) begin errors++; $display("FAIL frame_count: got %0d frames expected 7", rises); end
        checks++; if (frame_log.size() < 7) begin errors++; $display("FAIL frame_log_size: got %0d expected >=7", frame_log.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < frame_log.size()) begin
                w = frame_log[i];
                checks++;
                if (int'(w[13:11]) != exp_addr[i]) begin errors++; $display("FAIL addr_frame%0d: got %0d expected %0d", i, w[13:11], exp_addr[i]); end
                checks++;
                if ((w & 16'hC7FF) !== 16'h0000) begin errors++; $display("FAIL mosi_zero_bits_frame%0d: got %h expected 0000 outside 13:11", i, w); end
            end
        end
    endtask

    // ---------------- T3 mapping ----------------
    task automatic test_mapping();
        int n = 0;
        while (scan_done !== 1'b1 && n < FRAME) begin tick(); n++; end
        checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL first_scan_done: got %b expected 1 within %0d clks", scan_done, FRAME); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pot(i) !== 12'h100 + 12'(slot_ch[i])) begin
                errors++; $display("FAIL map_pot%0d: got %h expected %h", i, pot(i), 12'h100 + 12'(slot_ch[i]));
            end
        end
    endtask

    // ---------------- T4 timing ----------------
    task automatic test_timing();
        int   c = 0, fall0 = -1, fall1 = -1, sfalls = 0, srises = 0;
        int   lo_bad = 0, hi_bad = 0, last_fall = -1, last_rise = -1, front = -1;
        logic pss = SS_n, psc = SCLK;
        while (fall1 < 0 && c < 2 * FRAME + 100) begin
            tick(); c++;
            if (pss === 1'b1 && SS_n === 1'b0) begin
                if (fall0 < 0) fall0 = c; else fall1 = c;
            end
            if (fall0 >= 0 && fall1 < 0) begin
                if (psc === 1'b1 && SCLK === 1'b0) begin
                    if (sfalls == 0) front = c - fall0;
                    else if (c - last_rise != 16) hi_bad++;
                    sfalls++;
                    last_fall = c;
                end
                if (psc === 1'b0 && SCLK === 1'b1) begin
                    if (c - last_fall != 16) lo_bad++;
                    srises++;
                    last_rise = c;
                end
            end
            pss = SS_n; psc = SCLK;
        end
        checks++; if (fall1 < 0) begin errors++; $display("FAIL ss_fall_seen: got none expected two SS_n falls"); end
        checks++; if (fall1 - fall0 != FRAME) begin errors++; $display("FAIL frame_period: got %0d expected %0d", fall1 - fall0, FRAME); end
        checks++; if (sfalls != 16) begin errors++; $display("FAIL sclk_falls: got %0d expected 16", sfalls); end
        checks++; if (srises != 16) begin errors++; $display("FAIL sclk_rises: got %0d expected 16", srises); end
        checks++; if (front != 16) begin errors++; $display("FAIL front_hold: got %0d expected 16", front); end
        checks++; if (lo_bad != 0) begin errors++; $display("FAIL sclk_low_width: got %0d bad expected 0", lo_bad); end
        checks++; if (hi_bad != 0) begin errors++; $display("FAIL sclk_high_width: got %0d bad expected 0", hi_bad); end
    endtask

    // ---------------- T5 extremes ----------------
    task automatic test_extremes();
        int n = 0, c = 0, done_cnt = 0, vol_chg = 0, other_chg = 0, nchg;
        logic [11:0] prev [6];
        logic [11:0] exp_vol;
        do begin tick(); n++; end while (scan_done !== 1'b1 && n < 7 * FRAME);
        checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL scan_sync: got %b expected 1", scan_done); end
        val[7] = 12'hFFF;
        for (int i = 0; i < 6; i++) prev[i] = pot(i);
        while (done_cnt < 2 && c < 2 * SCAN + FRAME) begin
            tick(); c++;
            nchg = 0;
            for (int i = 0; i < 5; i++) if (pot(i) !== prev[i]) nchg++;
            if (volume !== prev[5]) begin
                vol_chg++;
                other_chg += nchg;
                checks++;
                if (scan_done !== 1'b1) begin errors++; $display("FAIL vol_write_scan_done: got %b expected 1", scan_done); end
            end
            if (scan_done === 1'b1) begin
                done_cnt++;
                exp_vol = (done_cnt == 1) ? 12'hFFF : 12'h000;
                checks++;
                if (c != done_cnt * SCAN) begin errors++; $display("FAIL scan_spacing%0d: got %0d expected %0d", done_cnt, c, done_cnt * SCAN); end
                checks++;
                if (volume !== exp_vol) begin errors++; $display("FAIL extreme_vol%0d: got %h expected %h", done_cnt, volume, exp_vol); end
                if (done_cnt == 1) val[7] = 12'h000;
            end
            for (int i = 0; i < 6; i++) prev[i] = pot(i);
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL scan_done_count: got %0d expected 2", done_cnt); end
        checks++; if (vol_chg != 2) begin errors++; $display("FAIL vol_update_count: got %0d expected 2", vol_chg); end
        checks++; if (other_chg != 0) begin errors++; $display("FAIL other_pot_on_vol_write: got %0d expected 0", other_chg); end
        tick();
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL scan_done_width: got %b expected 0", scan_done); end
    endtask

    // ---------------- T6 stability ----------------
    task automatic test_stability();
        int   n = 0, rises = 0, total = 0, bad_time = 0, multi = 0, nchg;
        logic pss, rose_prev = 1'b0, rose;
        logic [11:0] prev [6];
        while (SS_n !== 1'b0 && n < FRAME) begin tick(); n++; end
        repeat (300) tick();
        for (int ch = 0; ch < 8; ch++) val[ch] = 12'hA00 + 12'(ch);
        for (int i = 0; i < 6; i++) prev[i] = pot(i);
        pss = SS_n;
        n = 0;
        while (rises < 14 && n < 15 * FRAME) begin
            tick(); n++;
            nchg = 0;
            for (int i = 0; i < 6; i++) if (pot(i) !== prev[i]) nchg++;
            if (nchg > 0) begin
                total += nchg;
                if (!rose_prev) bad_time++;
                if (nchg > 1) multi++;
            end
            rose = (pss === 1'b0 && SS_n === 1'b1);
            if (rose) rises++;
            rose_prev = rose;
            pss = SS_n;
            for (int i = 0; i < 6; i++) prev[i] = pot(i);
        end
        checks++; if (rises != 14) begin errors++; $display("FAIL stab_frames: got %0d expected 14", rises); end
        checks++; if (bad_time != 0) begin errors++; $display("FAIL change_outside_back: got %0d expected 0", bad_time); end
        checks++; if (multi != 0) begin errors++; $display("FAIL multi_write: got %0d expected 0", multi); end
        checks++; if (total != 6) begin errors++; $display("FAIL change_total: got %0d expected 6", total); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pot(i) !== 12'hA00 + 12'(slot_ch[i])) begin
                errors++; $display("FAIL stab_pot%0d: got %h expected %h", i, pot(i), 12'hA00 + 12'(slot_ch[i]));
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < 8; ch++) val[ch] = 12'h100 + 12'(ch);
        test_reset();
        test_addressing();
        test_mapping();
        test_timing();
        test_extremes();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
